// File: rtl/uni_arb2_pkg.sv
// Shared definitions for the unified memory request interface arbiter:
// request type and size encodings plus the arbiter FSM state type.
package uni_arb2_pkg;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  localparam logic [1:0] SIZE_BYTE   = 2'b00;
  localparam logic [1:0] SIZE_HALF   = 2'b01;
  localparam logic [1:0] SIZE_WORD   = 2'b10;
  localparam logic [1:0] SIZE_DOUBLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

endpackage : uni_arb2_pkg

// File: rtl/uni_arb2.sv
// Two-master (icache m0, dcache m1) to one-slave arbiter in front of the
// uni-to-AXI bridge: registered round-robin grant, one transaction at a time.
module uni_arb2
  import uni_arb2_pkg::*;
#(
  parameter int unsigned UNI_ADDR_WIDTH = 32,
  parameter int unsigned UNI_DATA_WIDTH = 128,
  parameter int unsigned TIMEOUT_CYC    = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      m0_valid,
  input  logic                      m0_reqtyp,
  input  logic [UNI_ADDR_WIDTH-1:0] m0_addr,
  input  logic [1:0]                m0_size,
  input  logic                      m0_cachable,
  input  logic [UNI_DATA_WIDTH-1:0] m0_wdata,
  output logic                      m0_ready,
  output logic [UNI_DATA_WIDTH-1:0] m0_rdata,
  input  logic                      m1_valid,
  input  logic                      m1_reqtyp,
  input  logic [UNI_ADDR_WIDTH-1:0] m1_addr,
  input  logic [1:0]                m1_size,
  input  logic                      m1_cachable,
  input  logic [UNI_DATA_WIDTH-1:0] m1_wdata,
  output logic                      m1_ready,
  output logic [UNI_DATA_WIDTH-1:0] m1_rdata,
  output logic                      s_valid,
  output logic                      s_reqtyp,
  output logic [UNI_ADDR_WIDTH-1:0] s_addr,
  output logic [1:0]                s_size,
  output logic                      s_cachable,
  output logic [UNI_DATA_WIDTH-1:0] s_wdata,
  input  logic                      s_ready,
  input  logic [UNI_DATA_WIDTH-1:0] s_rdata,
  output logic                      o_timeout,
  output logic                      o_owner
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic busy;
  logic own_valid;

  // Tie goes to the port that did not win last; a lone requester always wins.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; combinational blocks below use blocking assignments.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          owner_d = rr_pick(m0_valid, m1_valid, last_owner_q);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (s_ready) begin
          state_d      = DONE;
          last_owner_d = owner_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (TIMEOUT_CYC != 0) begin
      if (state_q == IDLE && state_d == BUSY) begin
        cnt_d = '0;
      end else if (state_q == BUSY && cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (state_q == BUSY && cnt_d == CNT_MAX) timeout_d = 1'b1;
    end
  end

  assign busy      = (state_q == BUSY);
  assign own_valid = owner_q ? m1_valid : m0_valid;

  // Fields are forced to zero outside BUSY so the bridge sees a clean bus.
  always_comb begin
    s_valid    = busy & own_valid & ~s_ready;
    s_reqtyp   = REQ_READ;
    s_addr     = '0;
    s_size     = SIZE_BYTE;
    s_cachable = 1'b0;
    s_wdata    = '0;
    if (busy) begin
      s_reqtyp   = owner_q ? m1_reqtyp   : m0_reqtyp;
      s_addr     = owner_q ? m1_addr     : m0_addr;
      s_size     = owner_q ? m1_size     : m0_size;
      s_cachable = owner_q ? m1_cachable : m0_cachable;
      s_wdata    = owner_q ? m1_wdata    : m0_wdata;
    end
  end

  assign m0_ready  = s_ready & busy & ~owner_q;
  assign m1_ready  = s_ready & busy &  owner_q;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign o_timeout = timeout_q;
  assign o_owner   = owner_q;

endmodule : uni_arb2

// File: tb/tb_uni_arb2.sv
// Directed bench for uni_arb2: the bridge is modelled by hand-driven
// s_ready/s_rdata; every expected value is written out per cycle.
module tb_uni_arb2;
  import uni_arb2_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          m0_valid, m0_reqtyp, m0_cachable, m0_ready;
  logic [AW-1:0] m0_addr;
  logic [1:0]    m0_size;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_valid, m1_reqtyp, m1_cachable, m1_ready;
  logic [AW-1:0] m1_addr;
  logic [1:0]    m1_size;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          s_valid, s_reqtyp, s_cachable, s_ready;
  logic [AW-1:0] s_addr;
  logic [1:0]    s_size;
  logic [DW-1:0] s_wdata, s_rdata;
  logic          o_timeout, o_owner;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [DW-1:0] RD1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DW-1:0] RD2 = 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C;
  localparam logic [AW-1:0] A0  = 32'h0000_1000;
  localparam logic [AW-1:0] A1  = 32'h0000_2000;

  uni_arb2 #(
    .UNI_ADDR_WIDTH(AW),
    .UNI_DATA_WIDTH(DW),
    .TIMEOUT_CYC   (8)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .m0_valid   (m0_valid),
    .m0_reqtyp  (m0_reqtyp),
    .m0_addr    (m0_addr),
    .m0_size    (m0_size),
    .m0_cachable(m0_cachable),
    .m0_wdata   (m0_wdata),
    .m0_ready   (m0_ready),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_reqtyp  (m1_reqtyp),
    .m1_addr    (m1_addr),
    .m1_size    (m1_size),
    .m1_cachable(m1_cachable),
    .m1_wdata   (m1_wdata),
    .m1_ready   (m1_ready),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_reqtyp   (s_reqtyp),
    .s_addr     (s_addr),
    .s_size     (s_size),
    .s_cachable (s_cachable),
    .s_wdata    (s_wdata),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata),
    .o_timeout  (o_timeout),
    .o_owner    (o_owner)
  );

  always #5 i_clk = ~i_clk;

  // Owner must hold valid from its grant until its ready pulse.
  logic [1:0] txn_open;
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      txn_open <= 2'b00;
    end else begin
      if (s_valid)  txn_open[o_owner] <= 1'b1;
      if (m0_ready) txn_open[0] <= 1'b0;
      if (m1_ready) txn_open[1] <= 1'b0;
    end
  end

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      a_m0_hold: assert (!(txn_open[0] && !m0_valid)) else $error("m0 dropped valid mid-transaction");
      a_m1_hold: assert (!(txn_open[1] && !m1_valid)) else $error("m1 dropped valid mid-transaction");
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Each cycle: step past the edge, drive inputs, let combinational paths settle, check.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m0_reqtyp = REQ_READ; m0_addr = '0; m0_size = SIZE_BYTE;
    m0_cachable = 1'b0; m0_wdata = '0;
    m1_valid = 1'b0; m1_reqtyp = REQ_READ; m1_addr = '0; m1_size = SIZE_BYTE;
    m1_cachable = 1'b0; m1_wdata = '0;
    s_ready = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    #2;
    i_rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and single m0 read with five cycles of bridge latency.
    do_reset();
    settle();
    check("rst_s_valid", s_valid, 0);
    check("rst_m0_ready", m0_ready, 0);
    check("rst_m1_ready", m1_ready, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_owner", o_owner, 0);
    check("rst_s_addr", s_addr, 0);
    m0_valid = 1'b1; m0_reqtyp = REQ_READ; m0_addr = 32'h8000_0000;
    m0_size = SIZE_DOUBLE; m0_cachable = 1'b1;
    settle();
    check("t1_c0_s_valid", s_valid, 0);
    cyc(); settle();
    check("t1_c1_s_valid", s_valid, 1);
    check("t1_c1_s_addr", s_addr, 32'h8000_0000);
    check("t1_c1_s_cachable", s_cachable, 1);
    check("t1_c1_s_size", s_size, SIZE_DOUBLE);
    check("t1_c1_owner", o_owner, 0);
    for (int c = 2; c <= 5; c++) begin
      cyc(); settle();
      check("t1_busy_s_valid", s_valid, 1);
      check("t1_busy_m0_ready", m0_ready, 0);
      check("t1_busy_m1_ready", m1_ready, 0);
    end
    cyc(); s_ready = 1'b1; s_rdata = RD1; settle();
    check("t1_c6_m0_ready", m0_ready, 1);
    check("t1_c6_m0_rdata", m0_rdata, RD1);
    check("t1_c6_s_valid", s_valid, 0);
    check("t1_c6_m1_ready", m1_ready, 0);
    cyc(); s_ready = 1'b0; m0_valid = 1'b0; settle();
    check("t1_done_s_valid", s_valid, 0);
    check("t1_done_m0_ready", m0_ready, 0);
    cyc(); settle();
    check("t1_idle_s_valid", s_valid, 0);

    // Round robin from reset: m1, m0, m1, m0.
    do_reset();
    m0_valid = 1'b1; m0_addr = A0; m1_valid = 1'b1; m1_addr = A1;
    cyc(); settle();
    check("t2_g1_owner", o_owner, 1);
    check("t2_g1_s_addr", s_addr, A1);
    check("t2_g1_s_valid", s_valid, 1);
    cyc(); s_ready = 1'b1; s_rdata = RD2; settle();
    check("t2_g1_m1_ready", m1_ready, 1);
    check("t2_g1_m0_ready", m0_ready, 0);
    check("t2_g1_m1_rdata", m1_rdata, RD2);
    cyc(); s_ready = 1'b0; m1_valid = 1'b0; settle();
    check("t2_done_s_valid", s_valid, 0);
    cyc(); settle();
    check("t2_idle_s_valid", s_valid, 0);
    cyc(); settle();
    check("t2_g2_owner", o_owner, 0);
    check("t2_g2_s_addr", s_addr, A0);
    check("t2_g2_s_valid", s_valid, 1);
    cyc(); s_ready = 1'b1; settle();
    check("t2_g2_m0_ready", m0_ready, 1);
    check("t2_g2_m1_ready", m1_ready, 0);
    cyc(); s_ready = 1'b0; m0_valid = 1'b0; settle();
    cyc(); m0_valid = 1'b1; m1_valid = 1'b1; settle();
    cyc(); settle();
    check("t2_g3_owner", o_owner, 1);
    check("t2_g3_s_addr", s_addr, A1);
    cyc(); s_ready = 1'b1; settle();
    check("t2_g3_m1_ready", m1_ready, 1);
    cyc(); s_ready = 1'b0; m1_valid = 1'b0; settle();
    cyc(); settle();
    cyc(); settle();
    check("t2_g4_owner", o_owner, 0);
    check("t2_g4_s_addr", s_addr, A0);
    cyc(); s_ready = 1'b1; settle();
    check("t2_g4_m0_ready", m0_ready, 1);
    cyc(); s_ready = 1'b0; m0_valid = 1'b0; settle();
    cyc(); settle();

    // m1 write; m0 arrives mid-BUSY and must wait for the DONE+IDLE gap.
    m1_valid = 1'b1; m1_reqtyp = REQ_WRITE; m1_addr = 32'h1000_0008;
    m1_size = SIZE_WORD; m1_wdata = 128'hDEAD_BEEF; m1_cachable = 1'b0;
    cyc(); settle();
    check("t3_owner", o_owner, 1);
    check("t3_s_reqtyp", s_reqtyp, REQ_WRITE);
    check("t3_s_addr", s_addr, 32'h1000_0008);
    check("t3_s_size", s_size, SIZE_WORD);
    check("t3_s_wdata", s_wdata, 128'hDEAD_BEEF);
    check("t3_s_cachable", s_cachable, 0);
    cyc(); m0_valid = 1'b1; m0_reqtyp = REQ_READ; m0_addr = 32'h0000_0040;
    m0_cachable = 1'b1; settle();
    check("t3_hold_s_addr", s_addr, 32'h1000_0008);
    check("t3_hold_s_valid", s_valid, 1);
    check("t3_hold_m0_ready", m0_ready, 0);
    cyc(); settle();
    check("t3_hold_s_wdata", s_wdata, 128'hDEAD_BEEF);
    check("t3_hold_owner", o_owner, 1);
    cyc(); s_ready = 1'b1; settle();
    check("t3_m1_ready", m1_ready, 1);
    check("t3_m0_ready", m0_ready, 0);
    cyc(); s_ready = 1'b0; m1_valid = 1'b0; settle();
    check("t3_gap1_s_valid", s_valid, 0);
    cyc(); settle();
    check("t3_gap2_s_valid", s_valid, 0);
    cyc(); settle();
    check("t3_m0_s_valid", s_valid, 1);
    check("t3_m0_owner", o_owner, 0);
    check("t3_m0_s_addr", s_addr, 32'h0000_0040);

    // Owner keeps valid one cycle past its ready: no restart.
    cyc(); s_ready = 1'b1; settle();
    check("t4_m0_ready", m0_ready, 1);
    check("t4_ready_s_valid", s_valid, 0);
    cyc(); s_ready = 1'b0; settle();
    check("t4_done_s_valid", s_valid, 0);
    check("t4_done_m0_ready", m0_ready, 0);
    cyc(); m0_valid = 1'b0; settle();
    check("t4_idle_s_valid", s_valid, 0);
    cyc(); settle();
    check("t4_after_s_valid", s_valid, 0);

    // Bridge stalls: flag sets at the edge ending the 8th BUSY cycle, stays set.
    m0_valid = 1'b1; m0_addr = 32'h8000_0100;
    for (int k = 1; k <= 8; k++) begin
      cyc(); settle();
      check("t5_pre_timeout", o_timeout, 0);
    end
    cyc(); settle();
    check("t5_timeout_set", o_timeout, 1);
    check("t5_still_busy", s_valid, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(); settle();
      check("t5_timeout_sticky", o_timeout, 1);
    end
    cyc(); s_ready = 1'b1; settle();
    check("t5_m0_ready", m0_ready, 1);
    cyc(); s_ready = 1'b0; m0_valid = 1'b0; settle();
    check("t5_done_timeout", o_timeout, 1);
    check("t5_done_s_valid", s_valid, 0);
    cyc(); settle();
    check("t5_idle_timeout", o_timeout, 1);

    // Asynchronous reset in the middle of a BUSY cycle.
    m0_valid = 1'b1; m0_addr = 32'h8000_0200;
    cyc(); settle();
    check("t6_s_valid", s_valid, 1);
    s_ready = 1'b1;
    #1;
    check("t6_pre_m0_ready", m0_ready, 1);
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_s_valid", s_valid, 0);
    check("t6_rst_m0_ready", m0_ready, 0);
    check("t6_rst_m1_ready", m1_ready, 0);
    check("t6_rst_timeout", o_timeout, 0);
    check("t6_rst_s_addr", s_addr, 0);
    check("t6_rst_owner", o_owner, 0);
    s_ready = 1'b0; m0_valid = 1'b0;
    cyc(); cyc();
    #2;
    i_rst_n = 1'b1;
    m0_valid = 1'b1; m0_addr = A0; m1_valid = 1'b1; m1_addr = A1;
    m1_reqtyp = REQ_READ;
    settle();
    check("t6_rel_s_valid", s_valid, 0);
    cyc(); settle();
    check("t6_tie_owner", o_owner, 1);
    check("t6_tie_s_addr", s_addr, A1);
    cyc(); s_ready = 1'b1; settle();
    check("t6_m1_ready", m1_ready, 1);
    cyc(); idle_inputs();
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_uni_arb2
